// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write scoreboard for the register file.
//   Issue side marks the destination register busy. Writeback side clears it
//   and drives one-hot register-file write enables. Source side checks up to
//   NSRC operand addresses against the busy vector and raises a stall.
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   set_en/set_addr       issuing instruction's destination
//   clr_en/clr_addr       writeback destination
//   src_en/src_addr       per-port source lookups, port k at [k*ADDR_W +: ADDR_W]
//   wr_en                 one-hot write enables (combinational, not reset-gated)
//   busy, busy_cnt        registered busy vector and its popcount
//   src_busy, stall       per-port hazard and their OR (combinational)
//   err                   sticky: writeback to a register that was not busy
// Optional feature macro: SCOREBOARD_WB_FWD_EN. When it is defined, a register
//   being written back this cycle is reported free to the source lookups.
module reg_scoreboard #(
  parameter  int ADDR_W   = 5,
  parameter  int NSRC     = 2,
  parameter  int ZERO_REG = (1 << ADDR_W) - 1,
  localparam int NREGS    = 1 << ADDR_W,
  localparam int CNT_W    = $clog2(NREGS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   set_en,
  input  logic [ADDR_W-1:0]      set_addr,
  input  logic                   clr_en,
  input  logic [ADDR_W-1:0]      clr_addr,
  input  logic [NSRC-1:0]        src_en,
  input  logic [NSRC*ADDR_W-1:0] src_addr,
  output logic [NREGS-1:0]       wr_en,
  output logic [NREGS-1:0]       busy,
  output logic [NSRC-1:0]        src_busy,
  output logic                   stall,
  output logic [CNT_W-1:0]       busy_cnt,
  output logic                   err
);

  logic [NREGS-1:0] set_dec;
  logic [NREGS-1:0] busy_next;
  logic [NREGS-1:0] avail_busy;
  logic [CNT_W-1:0] cnt_next;
  logic             clr_miss;

  // Both decoders skip the zero register, so it can never become busy.
  for (genvar i = 0; i < NREGS; i++) begin : g_dec
    if (i == ZERO_REG) begin : g_zero
      assign wr_en[i]   = 1'b0;
      assign set_dec[i] = 1'b0;
    end else begin : g_reg
      assign wr_en[i]   = clr_en & (clr_addr == ADDR_W'(i));
      assign set_dec[i] = set_en & (set_addr == ADDR_W'(i));
    end
  end

  // Set is OR-ed in last, so a same-cycle set and clear keeps the bit busy.
  assign busy_next = (busy & ~wr_en) | set_dec;

  always_comb begin
    cnt_next = '0;
    for (int i = 0; i < NREGS; i++)
      cnt_next = cnt_next + CNT_W'(busy_next[i]);
  end

  assign clr_miss = clr_en & (clr_addr != ADDR_W'(ZERO_REG)) & ~busy[clr_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      busy     <= '0;
      busy_cnt <= '0;
      err      <= 1'b0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
      err      <= err | clr_miss;
    end
  end

`ifdef SCOREBOARD_WB_FWD_EN
  // The writeback data is forwardable this cycle, so the register counts as free.
  assign avail_busy = busy & ~wr_en;
`else
  assign avail_busy = busy;
`endif

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    reg_scoreboard_lane #(.ADDR_W(ADDR_W), .NREGS(NREGS)) u_lane (
      .en   (src_en[k]),
      .addr (src_addr[k*ADDR_W +: ADDR_W]),
      .busy (avail_busy),
      .hit  (src_busy[k])
    );
  end

  assign stall = |src_busy;

endmodule

// reg_scoreboard_lane: one source-operand lookup port.
//   en/addr  lookup valid and register address
//   busy     busy vector as seen by the sources this cycle
//   hit      hazard on this port
module reg_scoreboard_lane #(
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [NREGS-1:0]  busy,
  output logic              hit
);
  assign hit = en & busy[addr];
endmodule

// File: tb/tb_reg_scoreboard.sv
// Table-driven bench for reg_scoreboard. Each vector is one clock cycle:
// combinational outputs are checked before the edge, and the expected
// registered state is pushed to a queue and popped/compared after the edge.
module tb_reg_scoreboard;

`ifdef SCOREBOARD_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        set_en, clr_en;
  logic [4:0]  set_addr, clr_addr;
  logic [1:0]  src_en;
  logic [9:0]  src_addr;
  logic [31:0] wr_en, busy;
  logic [1:0]  src_busy;
  logic        stall, err;
  logic [5:0]  busy_cnt;

  reg_scoreboard dut (
    .clk(clk), .reset(reset),
    .set_en(set_en), .set_addr(set_addr),
    .clr_en(clr_en), .clr_addr(clr_addr),
    .src_en(src_en), .src_addr(src_addr),
    .wr_en(wr_en), .busy(busy), .src_busy(src_busy), .stall(stall),
    .busy_cnt(busy_cnt), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        set_en;
    logic [4:0]  set_addr;
    logic        clr_en;
    logic [4:0]  clr_addr;
    logic [1:0]  src_en;
    logic [4:0]  s0, s1;
    logic [31:0] exp_wr;
    logic [1:0]  exp_sb;
    logic [31:0] exp_busy;
    logic [5:0]  exp_cnt;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] busy;
    logic [5:0]  cnt;
    logic        err;
  } state_t;

  state_t exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One cycle: drive after the falling edge, check combinational outputs,
  // queue the expected post-edge state, then compare it after the rising edge.
  task automatic step(input string name, input vec_t v, input bit chk_comb);
    state_t s;
    @(negedge clk);
    reset    = v.rst;
    set_en   = v.set_en;  set_addr = v.set_addr;
    clr_en   = v.clr_en;  clr_addr = v.clr_addr;
    src_en   = v.src_en;  src_addr = {v.s1, v.s0};
    #1;
    if (chk_comb) begin
      check({name, ".wr_en"},    wr_en,    v.exp_wr);
      check({name, ".src_busy"}, 32'(src_busy), 32'(v.exp_sb));
      check({name, ".stall"},    32'(stall),    32'(|v.exp_sb));
    end
    exp_q.push_back('{busy: v.exp_busy, cnt: v.exp_cnt, err: v.exp_err});
    @(posedge clk);
    #1;
    s = exp_q.pop_front();
    check({name, ".busy"},     busy,         s.busy);
    check({name, ".busy_cnt"}, 32'(busy_cnt), 32'(s.cnt));
    check({name, ".err"},      32'(err),      32'(s.err));
  endtask

  vec_t vecs[13];
  vec_t v;

  initial begin
    reset = 1'b1; set_en = 0; set_addr = 0; clr_en = 0; clr_addr = 0;
    src_en = 0; src_addr = 0;

    //        rst se sa  ce ca  sen  s0  s1  wr_en          sb    busy           cnt err
    vecs[0]  = '{1, 1, 5,  0, 0,  2'b00, 0,  0,  32'h0,        2'b00, 32'h0,        0, 0}; // reset drops set
    vecs[1]  = '{0, 1, 3,  0, 0,  2'b00, 0,  0,  32'h0,        2'b00, 32'h8,        1, 0}; // set r3
    vecs[2]  = '{0, 0, 0,  0, 0,  2'b01, 3,  0,  32'h0,        2'b01, 32'h8,        1, 0}; // lookup r3 busy
    vecs[3]  = '{0, 0, 0,  1, 3,  2'b01, 3,  0,  32'h8,        FWD ? 2'b00 : 2'b01,
                                                                      32'h0,        0, 0}; // writeback r3
    vecs[4]  = '{0, 1, 31, 1, 31, 2'b11, 31, 3,  32'h0,        2'b00, 32'h0,        0, 0}; // zero register
    vecs[5]  = '{0, 1, 7,  0, 0,  2'b00, 0,  0,  32'h0,        2'b00, 32'h80,       1, 0}; // set r7
    vecs[6]  = '{0, 1, 7,  1, 7,  2'b10, 0,  7,  32'h80,       FWD ? 2'b00 : 2'b10,
                                                                      32'h80,       1, 0}; // set+clr r7
    vecs[7]  = '{0, 1, 1,  0, 0,  2'b11, 1,  7,  32'h0,        2'b10, 32'h82,       2, 0}; // same-cycle set invisible
    vecs[8]  = '{0, 0, 0,  1, 9,  2'b00, 0,  0,  32'h200,      2'b00, 32'h82,       2, 1}; // clr non-busy r9
    vecs[9]  = '{0, 0, 0,  0, 0,  2'b11, 9,  1,  32'h0,        2'b10, 32'h82,       2, 1}; // err sticky
    vecs[10] = '{1, 0, 0,  1, 1,  2'b00, 0,  0,  32'h2,        2'b00, 32'h0,        0, 0}; // reset, wr_en ungated
    vecs[11] = '{0, 1, 2,  1, 0,  2'b00, 0,  0,  32'h1,        2'b00, 32'h4,        1, 1}; // clr after reset -> err
    vecs[12] = '{1, 0, 0,  0, 0,  2'b00, 0,  0,  32'h0,        2'b00, 32'h0,        0, 0};

    // First row: busy is unknown before the first reset edge, skip comb checks.
    step("v0", vecs[0], 1'b0);
    for (int i = 1; i < 13; i++) step($sformatf("v%0d", i), vecs[i], 1'b1);

    // Fill registers 0..30, one per cycle, up to the full count.
    for (int i = 0; i < 31; i++) begin
      v = '{0, 1, 5'(i), 0, 0, 2'b01, 5'(i), 0, 32'h0, 2'b00,
            32'((64'd1 << (i + 1)) - 1), 6'(i + 1), 0};
      step($sformatf("fill%0d", i), v, 1'b1);
    end
    check("full.busy", busy, 32'h7FFF_FFFF);
    check("full.cnt",  32'(busy_cnt), 32'd31);
    v = '{0, 0, 0, 0, 0, 2'b11, 30, 31, 32'h0, 2'b01, 32'h7FFF_FFFF, 31, 0};
    step("full.lookup", v, 1'b1);

    // Reset in the middle of a second fill.
    v = '{1, 0, 0, 0, 0, 2'b00, 0, 0, 32'h0, 2'b00, 32'h0, 0, 0};
    step("rst0", v, 1'b1);
    for (int i = 0; i < 10; i++) begin
      v = '{0, 1, 5'(i), 0, 0, 2'b00, 0, 0, 32'h0, 2'b00,
            32'((64'd1 << (i + 1)) - 1), 6'(i + 1), 0};
      step($sformatf("refill%0d", i), v, 1'b1);
    end
    v = '{1, 1, 10, 0, 0, 2'b01, 4, 0, 32'h0, 2'b01, 32'h0, 0, 0};
    step("midrst", v, 1'b1);
    v = '{0, 0, 0, 0, 0, 2'b01, 4, 0, 32'h0, 2'b00, 32'h0, 0, 0};
    step("postrst", v, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
Parametrised pending-write scoreboard for the register file, built around two address decoders.
- Issue side: decodes the issuing instruction's destination address to mark that register busy.
- Writeback side: decodes the writeback address to clear the busy bit. It also drives the one-hot register-file write enables.
- Source side: compares up to NSRC source addresses against the busy vector and raises a stall.
- Sits between decode/issue and the register file. It replaces the fixed 5-to-32 write-enable decode with a generalised, stateful block.

Parameters:
ADDR_W, 5, register address width
NREGS, 2**ADDR_W, number of architectural registers (derived, not overridden)
NSRC, 2, number of source-operand lookup ports
ZERO_REG, NREGS-1, hardwired zero register index; never busy, never write-enabled
CNT_W, $clog2(NREGS+1), width of busy counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
set_en  input  1  issue of an instruction that writes set_addr
set_addr  input  ADDR_W  destination register of issuing instruction
clr_en  input  1  writeback valid this cycle
clr_addr  input  ADDR_W  writeback destination register
src_en  input  NSRC  per-port source lookup valid
src_addr  input  NSRC*ADDR_W  source addresses, port k at [k*ADDR_W +: ADDR_W]
wr_en  output  NREGS  one-hot register-file write enables (combinational)
busy  output  NREGS  registered busy vector
src_busy  output  NSRC  per-port source hazard (combinational)
stall  output  1  OR of src_busy
busy_cnt  output  CNT_W  registered count of busy registers
err  output  1  sticky: clear of a non-busy register seen

Behaviour:
Decode (combinational, zero latency):
- wr_en[i] = clr_en & (clr_addr == i) & (i != ZERO_REG). At most one bit is set.
- set_dec[i] = set_en & (set_addr == i) & (i != ZERO_REG). This is internal only.

Busy update (every rising clk edge):
- busy_next = (busy & ~wr_en) | set_dec.
- set and clr to the same register in the same cycle: set wins, and the bit stays/becomes 1.
- set to a register that is already busy: the bit stays 1. There is no error and no counting of multiple producers.
- clr of a non-busy register: busy is unchanged. err goes to 1 on the next edge and stays 1 until reset. ZERO_REG is excluded from this check.
- busy[ZERO_REG] is constant 0.

busy_cnt:
- Registered. busy_cnt_next = popcount(busy_next); it always equals popcount(busy) after the edge.
- Maximum value is NREGS-1; it cannot wrap.

Source lookup:
- src_busy[k] = src_en[k] & busy[src_addr_k], using the registered busy only.
- A set issued in the same cycle is NOT visible; that is the issue stage's responsibility.
- src_addr_k == ZERO_REG never reports busy.
- stall = |src_busy.

Reset:
- Synchronous. While reset=1 at an edge: busy=0, busy_cnt=0, err=0.
- set/clr presented in a reset cycle are discarded.
- wr_en stays purely combinational and is not gated by reset.
- Reset mid-operation drops all pending state. Writebacks arriving after reset clear non-busy bits and raise err. Upstream flush is required alongside reset.

Optional Feature:
Macro: SCOREBOARD_WB_FWD_EN.
- Defined: src_busy[k] = src_en[k] & busy[src_addr_k] & ~wr_en[src_addr_k]. A register being written back this cycle is reported free, allowing same-cycle writeback forwarding.
- If the same register also has set_dec this cycle, it is still reported free this cycle and busy next cycle.
- Not defined: src_busy uses the registered busy only, giving a one-cycle longer stall after writeback.

Test Plan:
- Reset, then set_en=1 set_addr=3 for one cycle -> next cycle busy=32'h0000_0008, busy_cnt=1; src_en=01, src_addr0=3 -> src_busy=01, stall=1.
- busy[3]=1, clr_en=1 clr_addr=3 -> wr_en=32'h0000_0008 same cycle; next cycle busy[3]=0, busy_cnt=0. With SCOREBOARD_WB_FWD_EN, src_busy0=0 during the clr cycle; without it, src_busy0=1.
- set_addr=31 and clr_addr=31 -> wr_en=0, busy unchanged, err stays 0; src_addr=31 -> src_busy=0.
- Same-cycle set_addr=7 and clr_addr=7 with busy[7]=1 -> busy[7]=1 next cycle, busy_cnt unchanged, wr_en[7]=1 in that cycle.
- clr_addr=9 with busy[9]=0 -> err=1 next cycle, busy unchanged; err stays 1 until reset=1, then err=0.
- Set registers 0..30 on consecutive cycles -> busy_cnt reaches 31, busy=32'h7FFF_FFFF. Assert reset mid-sequence -> busy=0 and busy_cnt=0 on the next edge.
